// File: rtl/request_vector_serializer.sv
// Streams the index of every set bit of an accepted request vector, highest first,
// one index per cycle over a valid/ready handshake, flagging the final beat.
//
// state | meaning
// IDLE  | no vector pending; ready to accept
// EMIT  | pending holds the remaining bits; top index presented on out_index
module request_vector_serializer #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vector,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic [IDX_W:0]   out_seq,
    output logic             zero_drop
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic [IDX_W:0]   seq_q;
    logic             zero_drop_q;
    logic [IDX_W-1:0] top_idx;
    logic             single_bit;
    logic             xfer;
    logic             accept;

    // Highest set bit wins: later iterations overwrite earlier ones.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending_q[i]) top_idx = IDX_W'(i);
        end
    end

    assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - 1'b1)) == '0);
    assign pending_d  = pending_q & ~(WIDTH'(1) << top_idx);

    assign out_valid = (state_q == EMIT);
    assign out_index = top_idx;
    assign out_last  = out_valid && single_bit;
    assign out_seq   = seq_q;
    assign zero_drop = zero_drop_q;

    // Accepting during the final transfer lets vectors stream with no idle gap.
    assign in_ready = !rst && ((state_q == IDLE) || (out_last && out_ready));
    assign xfer     = out_valid && out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            seq_q       <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            zero_drop_q <= 1'b0;
            if (accept) begin
                if (in_vector != '0) begin
                    pending_q <= in_vector;
                    seq_q     <= '0;
                    state_q   <= EMIT;
                end else begin
                    pending_q   <= '0;
                    state_q     <= IDLE;
                    zero_drop_q <= 1'b1;
                end
            end else if (xfer) begin
                pending_q <= pending_d;
                seq_q     <= seq_q + 1'b1;
                if (out_last) state_q <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_request_vector_serializer.sv
// Scoreboard bench for request_vector_serializer: WIDTH=8 directed sequences plus
// all-ones sweeps on WIDTH=2/4/6 instances.
module tb_request_vector_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vector;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_index;
    logic       out_last;
    logic [3:0] out_seq;
    logic       zero_drop;

    logic       w_valid;
    logic       r2, r4, r6, v2, v4, v6, l2, l4, l6, z2, z4, z6;
    logic [0:0] i2;
    logic [1:0] i4, s2;
    logic [2:0] i6, s4, s6;

    always #5 clk = ~clk;

    request_vector_serializer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_vector(in_vector), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_last(out_last), .out_seq(out_seq),
        .zero_drop(zero_drop));

    request_vector_serializer #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(r2), .in_vector(2'b11),
        .out_valid(v2), .out_ready(1'b1), .out_index(i2), .out_last(l2),
        .out_seq(s2), .zero_drop(z2));

    request_vector_serializer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(r4), .in_vector(4'hF),
        .out_valid(v4), .out_ready(1'b1), .out_index(i4), .out_last(l4),
        .out_seq(s4), .zero_drop(z4));

    request_vector_serializer #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(r6), .in_vector(6'h3F),
        .out_valid(v6), .out_ready(1'b1), .out_index(i6), .out_last(l6),
        .out_seq(s6), .zero_drop(z6));

    typedef struct {
        int idx;
        bit last;
        int seq;
    } beat_t;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_expect(input logic [7:0] v);
        int cnt;
        int seq;
        cnt = $countones(v);
        seq = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                sb.push_back('{idx: i, last: (seq == cnt - 1), seq: seq});
                seq++;
            end
        end
    endtask

    // Called right after a posedge; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] v);
        bit ok;
        in_valid  = 1'b1;
        in_vector = v;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        else push_expect(v);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_vector = 8'($urandom);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(out_index), 32'hFFFF_FFFF);
            end else begin
                chk("index", 32'(out_index), 32'(sb[0].idx));
                chk("last", 32'(out_last), 32'(sb[0].last));
                chk("seq", 32'(out_seq), 32'(sb[0].seq));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vector = 8'h00;
        out_ready = 1'b1;
        w_valid   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_index", 32'(out_index), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_seq", 32'(out_seq), 0);
        chk("rst_zero_drop", 32'(zero_drop), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 7, 5, 2 with in_ready low on the first two beats
        send(8'b1010_0100);
        @(negedge clk); chk("rdy_beat7", 32'(in_ready), 0);
        @(negedge clk); chk("rdy_beat5", 32'(in_ready), 0);
        @(negedge clk); chk("rdy_beat2", 32'(in_ready), 1);
        wait_drain();

        // back-to-back: no idle cycle between vectors
        send(8'h01);
        send(8'h80);
        @(negedge clk);
        chk("b2b_valid", 32'(out_valid), 1);
        chk("b2b_index", 32'(out_index), 7);
        wait_drain();

        // backpressure: index 2 held for 4 cycles
        out_ready = 1'b0;
        send(8'b0000_0110);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // zero vector from IDLE
        send(8'h00);
        @(negedge clk);
        chk("zd_pulse", 32'(zero_drop), 1);
        chk("zd_no_valid", 32'(out_valid), 0);
        chk("zd_ready", 32'(in_ready), 1);
        @(negedge clk);
        chk("zd_single", 32'(zero_drop), 0);
        @(posedge clk);
        #1;

        // zero vector accepted in a final-transfer cycle
        send(8'h02);
        send(8'h00);
        @(negedge clk);
        chk("zd_b2b_pulse", 32'(zero_drop), 1);
        chk("zd_b2b_valid", 32'(out_valid), 0);
        wait_drain();

        // reset mid-vector after 7, 6, 5 transfer
        send(8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_idle", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        send(8'h10);
        wait_drain();

        // all-ones on narrow widths
        w_valid = 1'b1;
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("w2_valid", 32'(v2), 32'(k < 2));
            chk("w4_valid", 32'(v4), 32'(k < 4));
            chk("w6_valid", 32'(v6), 32'(k < 6));
            if (k < 2) begin
                chk("w2_index", 32'(i2), 32'(1 - k));
                chk("w2_last", 32'(l2), 32'(k == 1));
            end
            if (k < 4) begin
                chk("w4_index", 32'(i4), 32'(3 - k));
                chk("w4_last", 32'(l4), 32'(k == 3));
            end
            if (k < 6) begin
                chk("w6_index", 32'(i6), 32'(5 - k));
                chk("w6_last", 32'(l6), 32'(k == 5));
                chk("w6_seq", 32'(s6), 32'(k));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
